// File: rtl/ysyx_22041412_div_gen_if.sv
// Request/response bundle for the iterative divider: issue-side request with flush,
// and writeback-side result, each with its own valid/ready pair.
interface ysyx_22041412_div_gen_if #(
  parameter int XLEN = 64
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            op_w;
  logic            op_signed;
  logic            op_rem;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  // Issue logic / writeback consumer side.
  modport master (
    output in_valid, dividend, divisor, op_w, op_signed, op_rem, flush, out_ready,
    input  in_ready, out_valid, result
  );

  // Divider side.
  modport slave (
    input  in_valid, dividend, divisor, op_w, op_signed, op_rem, flush, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/ysyx_22041412_div_gen.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU and W variants), one op in flight.
// Define DIV_EARLY_EXIT_EN to skip the leading-zero iterations of the dividend.
module ysyx_22041412_div_gen #(
  parameter int XLEN  = 64,
  parameter bit HAS_W = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_22041412_div_gen_if.slave bus
);

  localparam int              CW   = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] ONE  = XLEN'(1);
  localparam logic [XLEN-1:0] M32  = XLEN'(32'hFFFF_FFFF);
  localparam logic [XLEN-1:0] MIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  // Operation context captured at accept
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic [CW-1:0]   cnt_q;
  logic            w_q, sel_rem_q, neg_quo_q, neg_rem_q;

  // Accept-time decode
  logic            w_op, accept, a_sign, b_sign, div_zero, ovf, special, quick;
  logic [XLEN-1:0] mask_n, min_n, a_field, b_field, a_mag, b_mag, quo_init, special_res;
  logic [CW-1:0]   iters;
`ifdef DIV_EARLY_EXIT_EN
  logic [CW-1:0]   bit_len;
`endif

  // Iteration datapath
  logic [XLEN:0]   rem_shift, diff;
  logic            q_bit, last_iter;
  logic [XLEN-1:0] rem_nxt, quo_nxt, quo_fix, rem_fix, calc_res;

  // Sign-extend the low word for W ops; full-width ops pass through.
  function automatic logic [XLEN-1:0] ext_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    w_op    = HAS_W && bus.op_w;
    mask_n  = w_op ? M32 : '1;
    min_n   = w_op ? XLEN'(32'h8000_0000) : MIN;
    a_field = bus.dividend & mask_n;
    b_field = bus.divisor & mask_n;
    a_sign  = bus.op_signed && (w_op ? bus.dividend[31] : bus.dividend[XLEN-1]);
    b_sign  = bus.op_signed && (w_op ? bus.divisor[31] : bus.divisor[XLEN-1]);
    a_mag   = a_sign ? ((~a_field + ONE) & mask_n) : a_field;
    b_mag   = b_sign ? ((~b_field + ONE) & mask_n) : b_field;

    div_zero = (b_field == '0);
    ovf      = bus.op_signed && (a_field == min_n) && (b_field == mask_n);
    special  = div_zero || ovf;
    if (div_zero) special_res = ext_w(w_op, bus.op_rem ? a_field : mask_n);
    else          special_res = ext_w(w_op, bus.op_rem ? '0 : min_n);

`ifdef DIV_EARLY_EXIT_EN
    // Align the dividend's leading one to the MSB so only significant bits iterate.
    bit_len = '0;
    for (int i = 0; i < XLEN; i++) begin
      if (a_mag[i]) bit_len = CW'(i + 1);
    end
    iters    = bit_len;
    quo_init = a_mag << (CW'(XLEN) - bit_len);
`else
    iters    = w_op ? CW'(32) : CW'(XLEN);
    quo_init = w_op ? (a_mag << (XLEN - 32)) : a_mag;
`endif
    quick  = special || (iters == '0);
    accept = bus.in_valid && bus.in_ready && !bus.flush;
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = {rem_q, quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvsr_q};
    q_bit     = ~diff[XLEN];
    rem_nxt   = q_bit ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    quo_nxt   = {quo_q[XLEN-2:0], q_bit};
    quo_fix   = neg_quo_q ? (~quo_nxt + ONE) : quo_nxt;
    rem_fix   = neg_rem_q ? (~rem_nxt + ONE) : rem_nxt;
    calc_res  = ext_w(w_q, sel_rem_q ? rem_fix : quo_fix);
    last_iter = (cnt_q == CW'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = quick ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // A pipeline kill overrides both accept and the result handshake.
    if (bus.flush) state_nxt = IDLE;
  end

  always_comb begin
    bus.in_ready  = !rst && (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else if (accept && quick) begin
      result_q <= special ? special_res : '0;
    end else if (state == CALC && last_iter && !bus.flush) begin
      result_q <= calc_res;
    end
  end

  // NOTE: working registers carry no reset; they are always loaded at accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_q     <= '0;
      quo_q     <= quo_init;
      dvsr_q    <= b_mag;
      cnt_q     <= iters;
      w_q       <= w_op;
      sel_rem_q <= bus.op_rem;
      neg_quo_q <= a_sign ^ b_sign;
      neg_rem_q <= a_sign;
    end else if (state == CALC) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_div_gen.sv
// Directed bench for ysyx_22041412_div_gen: arithmetic, RISC-V corner cases, W ops,
// output back-pressure, flush and mid-op reset. Latencies follow DIV_EARLY_EXIT_EN.
module tb_ysyx_22041412_div_gen;

  localparam int XLEN = 64;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  ysyx_22041412_div_gen_if #(.XLEN(XLEN)) bus ();

  ysyx_22041412_div_gen #(.XLEN(XLEN), .HAS_W(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycle in which out_valid first rises: n = op width, k = bit length of |dividend|.
  function automatic int lat(input int n, input int k);
    return EE ? k + 1 : n + 1;
  endfunction

  task automatic start(input logic [63:0] a, input logic [63:0] b,
                       input logic w, input logic s, input logic r);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.op_w      = w;
    bus.op_signed = s;
    bus.op_rem    = r;
    bus.in_valid  = 1'b1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      step();
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic w, input logic s, input logic r,
                        input logic [63:0] exp, input int exp_lat);
    int cyc;
    start(a, b, w, s, r);
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    step();
    bus.in_valid = 1'b0;
    check({tag, " busy"}, 64'(bus.in_ready), 64'd0);
    wait_valid(cyc);
    check({tag, " latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, " result"}, bus.result, exp);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " drained"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic seen;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.op_w      = 1'b0;
    bus.op_signed = 1'b0;
    bus.op_rem    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    step();
    step();
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset result", bus.result, 64'd0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

    // Unsigned 64-bit
    run_op("divu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd14, lat(64, 7));
    run_op("remu 100/7", 64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd2, lat(64, 7));
    run_op("divu max/2", ONES, 64'd2, 1'b0, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, lat(64, 64));
    run_op("remu max/2", ONES, 64'd2, 1'b0, 1'b0, 1'b1, 64'd1, lat(64, 64));
    run_op("divu zero", 64'd0, 64'd3, 1'b0, 1'b0, 1'b0, 64'd0, lat(64, 0));

    // Signed 64-bit
    run_op("div -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, lat(64, 3));
    run_op("rem -7/2", 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b1, 1'b1, ONES, lat(64, 3));
    run_op("rem 7/-2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b1, 64'd1, lat(64, 3));
    run_op("div 7/-2", 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, lat(64, 3));

    // W ops
    run_op("divw min/1", 64'h0000_0001_8000_0000, 64'd1, 1'b1, 1'b1, 1'b0,
           64'hFFFF_FFFF_8000_0000, lat(32, 32));
    run_op("divuw ffffffff/1", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 1'b0, 1'b0, ONES, lat(32, 32));
    run_op("divw -7/2", 64'h0000_0000_FFFF_FFF9, 64'd2, 1'b1, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFD, lat(32, 3));

    // Corner cases resolved at accept
    run_op("div 5/0", 64'd5, 64'd0, 1'b0, 1'b1, 1'b0, ONES, 1);
    run_op("rem 5/0", 64'd5, 64'd0, 1'b0, 1'b1, 1'b1, 64'd5, 1);
    run_op("div min/-1", 64'h8000_0000_0000_0000, ONES, 1'b0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1);
    run_op("rem min/-1", 64'h8000_0000_0000_0000, ONES, 1'b0, 1'b1, 1'b1, 64'd0, 1);
    run_op("remuw x/0", 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 1'b1, 1'b0, 1'b1,
           64'hFFFF_FFFF_8000_0005, 1);
    run_op("divw min/-1", 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 1'b0,
           64'hFFFF_FFFF_8000_0000, 1);

    // Back-pressure: result held while out_ready is low
    start(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    check("hold latency", 64'(cyc), 64'(lat(64, 7)));
    for (int i = 0; i < 10; i++) begin
      check("hold out_valid", 64'(bus.out_valid), 64'd1);
      check("hold result", bus.result, 64'd14);
      check("hold in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("hold release out_valid", 64'(bus.out_valid), 64'd0);
    check("hold release in_ready", 64'(bus.in_ready), 64'd1);
    run_op("after hold", 64'd81, 64'd9, 1'b0, 1'b0, 1'b0, 64'd9, lat(64, 7));

    // Flush while idle is a no-op and blocks the accept
    start(64'd10, 64'd2, 1'b0, 1'b0, 1'b0);
    bus.flush = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("idle flush in_ready", 64'(bus.in_ready), 64'd1);
    step();
    check("idle flush out_valid", 64'(bus.out_valid), 64'd0);

    // Flush in cycle 20 of CALC
    start(ONES, 64'd3, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    repeat (19) step();
    check("flush calc in_ready", 64'(bus.in_ready), 64'd0);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      seen |= bus.out_valid;
      step();
    end
    check("flush no out_valid", 64'(seen), 64'd0);

    // Reset in cycle 10 of CALC
    start(ONES, 64'd3, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    #1;
    check("rst mid-op in_ready", 64'(bus.in_ready), 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst release in_ready", 64'(bus.in_ready), 64'd1);
    seen = 1'b0;
    repeat (80) begin
      seen |= bus.out_valid;
      step();
    end
    check("rst no out_valid", 64'(seen), 64'd0);
    run_op("after rst", 64'd1000, 64'd10, 1'b0, 1'b1, 1'b0, 64'd100, lat(64, 10));

    // Flush coincident with the result handshake
    start(64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
    step();
    bus.in_valid = 1'b0;
    check("done flush out_valid pre", 64'(bus.out_valid), 64'd1);
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    check("done flush out_valid", 64'(bus.out_valid), 64'd0);
    check("done flush in_ready", 64'(bus.in_ready), 64'd1);
    run_op("after done flush", 64'd50, 64'd5, 1'b0, 1'b0, 1'b1, 64'd0, lat(64, 6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
